arcsin_search: RTL
==================

# arcsin_search

Inverse of the sine look-up path. Accepts an IEEE-754 double (the format `sine_LUT` produces on `data_out`) and returns the integer angle in degrees whose tabulated sine is the largest value not exceeding the input magnitude. It uses a fixed-length sequential binary search over an internal 91-entry table. The table is bit-identical to the sine_LUT first-quadrant table. The block sits downstream of the DFPU as the angle-recovery stage.

## Interface
- `DATA_WIDTH`, default 32: angle width. The double input is 2*DATA_WIDTH = 64 bits.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `data_in`  in  2*DATA_WIDTH  IEEE-754 double operand. Latched on an accepted start.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse; all result outputs are valid in that cycle.
- `angle_out`  out  DATA_WIDTH  result angle, range 0..90.
- `quadrant_out`  out  2  2'b00 for a positive input, 2'b11 for a negative input (see Configuration).
- `exact`  out  1  table entry equals the input magnitude bit-for-bit.
- `invalid`  out  1  input is NaN, ±Inf, or has |x| > 1.0.

## Operation
- FSM states: IDLE → CHECK → SEARCH → DONE → IDLE.
- **IDLE**
  - On `start`=1, latch `data_in` into an internal register and go to CHECK.
  - `start` is ignored in every other state.
- **CHECK** (1 cycle): classify the latched operand.
  - mag = bits [62:0]; sgn = bit 63.
  - NaN/Inf: exponent field is all ones.
  - Over-range: mag > 0x3FF0000000000000.
  - -0.0 is treated as +0.0, so sgn is forced to 0.
  - Invalid operand: go straight to DONE with `invalid`=1.
  - Otherwise clear idx to 0, load bit counter b=6, go to SEARCH.
- **SEARCH** (exactly 7 cycles, b = 6..0)
  - Each cycle: cand = idx | (1<<b). If cand ≤ 90 and T[cand] ≤ mag (unsigned 63-bit compare), then idx ← cand.
  - Decrement b each cycle. Leave to DONE after the b=0 cycle.
  - The search never reads T[91..127].
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- Result mapping:
  - `angle_out` = idx, zero-extended.
  - `exact` = (T[idx] == mag).
  - `quadrant_out` = {sgn, sgn}.
- On invalid: `angle_out`=0, `quadrant_out`=0, `exact`=0, `invalid`=1.
- Result registers hold their values until the next accepted start. They update in the DONE cycle.
- T[k] is the correctly rounded double of sin(k°), k = 0..90. T[0]=0, T[30]=0x3FE0000000000000, T[90]=0x3FF0000000000000.
- Subnormal inputs need no special handling: the integer compare orders them correctly, so they yield angle 0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Valid operand: `done` is high in cycle 9. Latency is fixed and data-independent.
- Invalid operand: `done` is high in cycle 2.
- `busy` is high in cycles 1..9 (valid operand) or 1..2 (invalid operand), and low in IDLE.
- Earliest next acceptance is the cycle after DONE, so back-to-back throughput is one result per 10 cycles.
- Reset values:
  - State = IDLE.
  - `busy`=0, `done`=0, `angle_out`=0, `quadrant_out`=0, `exact`=0, `invalid`=0.
- Reset asserted mid-operation:
  - Abort immediately and return to IDLE with the reset values above.
  - No `done` pulse is generated for the aborted operation.
- `reset` and `start` in the same cycle: reset wins and the start is dropped.

## Configuration
- Macro: `ARCSIN_NEG_QUADRANT_EN`.
- Defined: negative finite inputs with |x| ≤ 1.0 are searched on their magnitude. They report `quadrant_out`=2'b11 with the angle of |x|.
- Undefined: any input with bit 63 = 1 and nonzero mag is flagged `invalid` in CHECK, with `done` in cycle 2. -0.0 remains valid and returns angle 0.

## Test plan
- 0x3FE0000000000000 (0.5) → `angle_out`=30, `exact`=1, `quadrant_out`=00, `done` in cycle 9 only, `busy` high in cycles 1..9.
- 0x3FF0000000000000 → 90, `exact`=1. Then 0x0000000000000000 → 0, `exact`=1. Then 0x3FE0000000000001 → 30, `exact`=0.
- Sweep all T[k], k = 0..90, with back-to-back starts → `angle_out`=k, `exact`=1 each time. Also check that a start asserted while `busy` is ignored.
- 0x3FF0000000000001, 0x7FF0000000000000 and 0x7FF8000000000000 → `invalid`=1, `angle_out`=0, `done` in cycle 2.
- 0xBFE0000000000000 (-0.5): with the macro defined → 30, `quadrant_out`=11. With it undefined → `invalid`=1 in cycle 2. In both builds, 0x8000000000000000 → 0, `quadrant_out`=00.
- Assert `reset` in cycle 5 of a search → no `done` pulse and all outputs return to the reset values. A new start in the next cycle completes normally.

Source files
------------

// File: rtl/arcsin_search.sv
`default_nettype none
// ============================================================================
// Module      : arcsin_search
// Description : Double -> integer-degree angle via a 7-step binary search over
//               a 91-entry first-quadrant sine table. Optional feature macro:
//               ARCSIN_NEG_QUADRANT_EN (search negative inputs on |x|).
// Revision    : 1.0 - initial release
// ============================================================================
module arcsin_search #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] data_in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   angle_out,
  output logic [1:0]              quadrant_out,
  output logic                    exact,
  output logic                    invalid
);

  localparam int          FRAC     = 120;
  localparam logic [255:0] PI_FX   = {132'd0, 124'h3243F6A8885A308D313198A2E037073};
  localparam logic [62:0] ONE_MAG  = 63'h3FF0000000000000;

  // Correctly rounded sin(k deg) as a double magnitude, evaluated at elaboration
  // with a 120-bit fixed-point Taylor series and round-to-nearest-even.
  function automatic logic [62:0] sin_deg_bits(input logic [6:0] k);
    logic [255:0] x, x2, term, sum, rem, half;
    logic [53:0]  m;
    int           p;
    if (k == 7'd0) return 63'd0;
    x    = (PI_FX * {249'd0, k}) / 256'd180;
    x2   = (x * x) >> FRAC;
    term = x;
    sum  = x;
    for (int n = 1; n <= 24; n++) begin
      term = ((term * x2) >> FRAC) / 256'(2 * n * (2 * n + 1));
      sum  = n[0] ? (sum - term) : (sum + term);
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (sum[i]) p = i;
    m    = 54'(sum >> (p - 52));
    rem  = sum & ((256'd1 << (p - 52)) - 256'd1);
    half = 256'd1 << (p - 53);
    if ((rem > half) || ((rem == half) && m[0])) m = m + 54'd1;
    if (m[53]) begin
      m = m >> 1;
      p = p + 1;
    end
    return {11'(p - FRAC + 1023), m[51:0]};
  endfunction

  logic [62:0] tab [0:90];
  for (genvar g = 0; g <= 90; g++) begin : g_tab
    localparam logic [62:0] C_VAL = sin_deg_bits(7'(g));
    assign tab[g] = C_VAL;
  end

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SEARCH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [63:0]             opnd_q, opnd_d;
  logic [6:0]              idx_q, idx_d;
  logic [2:0]              bit_q, bit_d;
  logic                    eq_q, eq_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   angle_q, angle_d;
  logic [1:0]              quad_q, quad_d;
  logic                    exact_q, exact_d;
  logic                    invalid_q, invalid_d;

  logic [62:0] mag;
  logic        sgn, nan_inf, over, bad, take;
  logic [6:0]  cand, cand_rd;

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    eq_d      = eq_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    angle_d   = angle_q;
    quad_d    = quad_q;
    exact_d   = exact_q;
    invalid_d = invalid_q;

    mag     = opnd_q[62:0];
    sgn     = opnd_q[63] & (|mag);
    nan_inf = &opnd_q[62:52];
    over    = mag > ONE_MAG;
`ifdef ARCSIN_NEG_QUADRANT_EN
    bad     = nan_inf | over;
`else
    bad     = nan_inf | over | sgn;
`endif
    cand    = idx_q | (7'd1 << bit_q);
    // Clamp the read index so the table is never addressed past entry 90.
    cand_rd = (cand <= 7'd90) ? cand : 7'd90;
    take    = (cand <= 7'd90) && (tab[cand_rd] <= mag);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opnd_d  = data_in[63:0];
          state_d = S_CHECK;
          busy_d  = 1'b1;
        end
      end
      S_CHECK: begin
        if (bad) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          angle_d   = '0;
          quad_d    = 2'b00;
          exact_d   = 1'b0;
          invalid_d = 1'b1;
        end else begin
          idx_d   = 7'd0;
          bit_d   = 3'd6;
          eq_d    = (tab[0] == mag);
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (take) begin
          idx_d = cand;
          eq_d  = (tab[cand_rd] == mag);
        end
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          angle_d   = DATA_WIDTH'(idx_d);
          quad_d    = {sgn, sgn};
          exact_d   = eq_d;
          invalid_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opnd_q    <= '0;
      idx_q     <= '0;
      bit_q     <= '0;
      eq_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      angle_q   <= '0;
      quad_q    <= 2'b00;
      exact_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      eq_q      <= eq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      angle_q   <= angle_d;
      quad_q    <= quad_d;
      exact_q   <= exact_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign angle_out    = angle_q;
  assign quadrant_out = quad_q;
  assign exact        = exact_q;
  assign invalid      = invalid_q;

endmodule
`default_nettype wire
